// File: rtl/sysid_check_master.sv
// Avalon-MM read master that reads the system-ID slave (ID at word 0, timestamp at word 1)
// and reports whether both match the values the software build expects.
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h0000_0000,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES     = 1024,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, FINISH} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic        auto_q;
  logic [15:0] cnt_q, cnt_d;
  logic        read_q, addr_q, busy_q, done_q;
  logic        id_ok_q, ts_ok_q, timeout_q;
  logic [31:0] id_value_q, ts_value_q;
  logic        accept, id_cap, ts_cap, to_hit;

  // A zero-latency slave returns data in the acceptance cycle, so capture is
  // legal in REQ_x only when waitrequest is low; earlier readdatavalid is ignored.
  always_comb begin
    cnt_d  = cnt_q + 16'd1;
    accept = ((state_q == REQ_ID) || (state_q == REQ_TS)) && !avm_waitrequest;
    id_cap = avm_readdatavalid &&
             ((state_q == WAIT_ID) || ((state_q == REQ_ID) && !avm_waitrequest));
    ts_cap = avm_readdatavalid &&
             ((state_q == WAIT_TS) || ((state_q == REQ_TS) && !avm_waitrequest));
    to_hit = (cnt_q >= TO_LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      auto_q     <= AUTO_START;
      cnt_q      <= '0;
      read_q     <= 1'b0;
      addr_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      unique case (state_q)
        IDLE: begin
          if (start || auto_q) begin
            auto_q    <= 1'b0;
            state_q   <= REQ_ID;
            read_q    <= 1'b1;
            addr_q    <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
          end
        end
        REQ_ID, WAIT_ID: begin
          if (id_cap) begin
            id_value_q <= avm_readdata;
            id_ok_q    <= (avm_readdata == EXPECTED_ID);
            if (CHECK_TIMESTAMP) begin
              state_q <= REQ_TS;
              read_q  <= 1'b1;
              addr_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              ts_ok_q    <= 1'b1;
              ts_value_q <= '0;
              read_q     <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= FINISH;
            end
          end else if (accept) begin
            read_q  <= 1'b0;
            state_q <= WAIT_ID;
          end else if (to_hit) begin
            read_q    <= 1'b0;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= FINISH;
          end
        end
        REQ_TS, WAIT_TS: begin
          if (ts_cap) begin
            ts_value_q <= avm_readdata;
            ts_ok_q    <= (avm_readdata == EXPECTED_TIMESTAMP);
            read_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= FINISH;
          end else if (accept) begin
            read_q  <= 1'b0;
            state_q <= WAIT_TS;
          end else if (to_hit) begin
            read_q    <= 1'b0;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= FINISH;
          end
        end
        FINISH: state_q <= IDLE;
      endcase
    end
  end

  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed bench for sysid_check_master: two instances (full check with auto-start,
// ID-only check) each driven by a small configurable Avalon slave.
module tb_sysid_check_master;

  localparam logic [31:0] EXP_ID = 32'h64A4_C5FC;
  localparam logic [31:0] EXP_TS = 32'h4C8F_1A20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2], start[2], wreq[2], rdv[2];
  logic [31:0] rdata[2];
  logic        rd[2], addr[2], busy[2], done[2], id_ok[2], ts_ok[2], tmo[2];
  logic [31:0] idv[2], tsv[2];

  // slave configuration (written by the stimulus process only)
  bit          lat0[2], mute1[2];
  int          wait_id[2], inj_req[2];
  logic [31:0] data0[2], data1[2], inj_data;

  // slave state (written by the slave process only)
  bit in_req[2], pend[2], pend_addr[2], req_addr[2];
  int wait_left[2], accepts[2], stall_seen[2], stall_bad[2], inj_ack[2];

  int n_tests = 0;
  int n_fail  = 0;

  sysid_check_master #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .CHECK_TIMESTAMP(1'b1),
    .TIMEOUT_CYCLES(16), .AUTO_START(1'b1)
  ) u_a (
    .clock(clk), .reset(rst[0]), .start(start[0]),
    .avm_address(addr[0]), .avm_read(rd[0]), .avm_waitrequest(wreq[0]),
    .avm_readdata(rdata[0]), .avm_readdatavalid(rdv[0]),
    .busy(busy[0]), .done(done[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]),
    .timeout(tmo[0]), .id_value(idv[0]), .ts_value(tsv[0])
  );

  sysid_check_master #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .CHECK_TIMESTAMP(1'b0),
    .TIMEOUT_CYCLES(1024), .AUTO_START(1'b0)
  ) u_b (
    .clock(clk), .reset(rst[1]), .start(start[1]),
    .avm_address(addr[1]), .avm_read(rd[1]), .avm_waitrequest(wreq[1]),
    .avm_readdata(rdata[1]), .avm_readdatavalid(rdv[1]),
    .busy(busy[1]), .done(done[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]),
    .timeout(tmo[1]), .id_value(idv[1]), .ts_value(tsv[1])
  );

  // Slave: reacts mid-cycle to the registered master outputs.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      wreq[i]  = 1'b0;
      rdv[i]   = 1'b0;
      rdata[i] = '0;
      if (rst[i]) begin
        in_req[i] = 1'b0;
        pend[i]   = 1'b0;
      end else begin
        if (pend[i]) begin
          pend[i] = 1'b0;
          if (!(mute1[i] && pend_addr[i])) begin
            rdv[i]   = 1'b1;
            rdata[i] = pend_addr[i] ? data1[i] : data0[i];
          end
        end
        if (inj_req[i] != inj_ack[i]) begin
          inj_ack[i] = inj_req[i];
          rdv[i]     = 1'b1;
          rdata[i]   = inj_data;
        end
        if (in_req[i] && (!rd[i] || addr[i] != req_addr[i])) begin
          stall_bad[i]++;
          in_req[i] = 1'b0;
        end
        if (rd[i]) begin
          if (!in_req[i]) begin
            in_req[i]    = 1'b1;
            req_addr[i]  = addr[i];
            wait_left[i] = addr[i] ? 0 : wait_id[i];
          end
          if (wait_left[i] > 0) begin
            wreq[i] = 1'b1;
            wait_left[i]--;
            stall_seen[i]++;
          end else begin
            in_req[i] = 1'b0;
            accepts[i]++;
            if (lat0[i]) begin
              if (!(mute1[i] && addr[i])) begin
                rdv[i]   = 1'b1;
                rdata[i] = addr[i] ? data1[i] : data0[i];
              end
            end else begin
              pend[i]      = 1'b1;
              pend_addr[i] = addr[i];
            end
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Pulses start in cycle 0; reports first cycle with avm_read and with done (-1 if none).
  task automatic run_check(input int i, input int budget, output int rd_cyc, output int dn_cyc,
                           output logic busy_before, output logic busy_at);
    rd_cyc = -1;
    dn_cyc = -1;
    busy_before = 1'b0;
    busy_at = 1'b1;
    @(negedge clk);
    start[i] = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      busy_before = busy[i];
      @(negedge clk);
      start[i] = 1'b0;
      if (rd_cyc < 0 && rd[i]) rd_cyc = k;
      if (done[i]) begin
        dn_cyc  = k;
        busy_at = busy[i];
        break;
      end
    end
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, output int cyc);
    cyc = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (done[i]) begin
        cyc = k;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   rc, dc, cyc, acc0, stl0, bad0;
    logic bb, ba;
    rst[0] = 1'b1; rst[1] = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    lat0[0] = 1'b0; wait_id[0] = 0; data0[0] = EXP_ID; data1[0] = EXP_TS; mute1[0] = 1'b0;
    lat0[1] = 1'b1; wait_id[1] = 0; data0[1] = EXP_ID; data1[1] = 32'hFFFF_FFFF; mute1[1] = 1'b0;
    inj_data = '0;
    repeat (3) @(negedge clk);

    check("rst_read",    32'(rd[0]),   32'd0);
    check("rst_busy",    32'(busy[0]), 32'd0);
    check("rst_done",    32'(done[0]), 32'd0);
    check("rst_id_ok",   32'(id_ok[0]), 32'd0);
    check("rst_ts_ok",   32'(ts_ok[0]), 32'd0);
    check("rst_timeout", 32'(tmo[0]),  32'd0);
    check("rst_id_val",  idv[0],       32'd0);
    check("rst_ts_val",  tsv[0],       32'd0);

    // auto-start after reset release (instance A), none on instance B
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    check("auto_read_rise", 32'(rd[0]), 32'd1);
    check("b_no_auto",      32'(rd[1]), 32'd0);
    wait_done(0, 40, cyc);
    check("auto_done_seen", 32'(cyc > 0), 32'd1);
    check("auto_id_ok",     32'(id_ok[0]), 32'd1);
    check("auto_ts_ok",     32'(ts_ok[0]), 32'd1);
    check("b_idle_busy",    32'(busy[1]), 32'd0);

    // nominal: 1-cycle latency, no waits
    lat0[0] = 1'b0;
    acc0 = accepts[0];
    run_check(0, 40, rc, dc, bb, ba);
    check("nom_read_cyc",  rc, 32'd1);
    check("nom_done_cyc",  dc, 32'd5);
    check("nom_busy_pre",  32'(bb), 32'd1);
    check("nom_busy_done", 32'(ba), 32'd0);
    check("nom_id_ok",     32'(id_ok[0]), 32'd1);
    check("nom_ts_ok",     32'(ts_ok[0]), 32'd1);
    check("nom_timeout",   32'(tmo[0]), 32'd0);
    check("nom_id_val",    idv[0], EXP_ID);
    check("nom_ts_val",    tsv[0], EXP_TS);
    check("nom_reads",     accepts[0] - acc0, 32'd2);

    // ID mismatch
    data0[0] = 32'h0000_0001;
    acc0 = accepts[0];
    run_check(0, 40, rc, dc, bb, ba);
    check("mis_done_cyc", dc, 32'd5);
    check("mis_id_val",   idv[0], 32'h0000_0001);
    check("mis_id_ok",    32'(id_ok[0]), 32'd0);
    check("mis_ts_ok",    32'(ts_ok[0]), 32'd1);
    check("mis_reads",    accepts[0] - acc0, 32'd2);
    data0[0] = EXP_ID;

    // 7-cycle waitrequest stall on the ID read
    wait_id[0] = 7;
    acc0 = accepts[0]; stl0 = stall_seen[0]; bad0 = stall_bad[0];
    run_check(0, 40, rc, dc, bb, ba);
    check("stall_done_cyc", dc, 32'd12);
    check("stall_cycles",   stall_seen[0] - stl0, 32'd7);
    check("stall_stable",   stall_bad[0] - bad0, 32'd0);
    check("stall_reads",    accepts[0] - acc0, 32'd2);
    check("stall_id_ok",    32'(id_ok[0]), 32'd1);
    check("stall_ts_ok",    32'(ts_ok[0]), 32'd1);
    wait_id[0] = 0;

    // timestamp never answered: REQ_TS entered in cycle 3, abort visible 16 cycles later
    mute1[0] = 1'b1;
    run_check(0, 60, rc, dc, bb, ba);
    check("to_done_cyc", dc, 32'd19);
    check("to_flag",     32'(tmo[0]), 32'd1);
    check("to_id_ok",    32'(id_ok[0]), 32'd1);
    check("to_ts_ok",    32'(ts_ok[0]), 32'd0);
    check("to_read",     32'(rd[0]), 32'd0);
    check("to_busy",     32'(busy[0]), 32'd0);
    inj_data = 32'hDEAD_BEEF;
    inj_req[0]++;
    repeat (4) @(negedge clk);
    check("late_ts_val",  tsv[0], EXP_TS);
    check("late_ts_ok",   32'(ts_ok[0]), 32'd0);
    check("late_timeout", 32'(tmo[0]), 32'd1);
    check("late_done",    32'(done[0]), 32'd1);
    mute1[0] = 1'b0;

    // reset during cycle 2 of a stalled ID read
    wait_id[0] = 7;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    check("mrst_read",    32'(rd[0]),   32'd0);
    check("mrst_busy",    32'(busy[0]), 32'd0);
    check("mrst_done",    32'(done[0]), 32'd0);
    check("mrst_id_ok",   32'(id_ok[0]), 32'd0);
    check("mrst_ts_ok",   32'(ts_ok[0]), 32'd0);
    check("mrst_timeout", 32'(tmo[0]),  32'd0);
    check("mrst_id_val",  idv[0],       32'd0);
    check("mrst_ts_val",  tsv[0],       32'd0);
    rst[0] = 1'b0;
    wait_id[0] = 0;
    @(negedge clk);
    check("mrst_auto_read", 32'(rd[0]), 32'd1);
    wait_done(0, 40, cyc);
    check("mrst_done_seen", 32'(cyc > 0), 32'd1);
    check("mrst_rerun_id",  32'(id_ok[0]), 32'd1);
    check("mrst_rerun_ts",  32'(ts_ok[0]), 32'd1);
    check("mrst_rerun_to",  32'(tmo[0]),  32'd0);

    // instance B: ID-only, zero-latency slave
    acc0 = accepts[1];
    run_check(1, 20, rc, dc, bb, ba);
    check("b_read_cyc", rc, 32'd1);
    check("b_done_cyc", dc, 32'd2);
    check("b_reads",    accepts[1] - acc0, 32'd1);
    check("b_id_ok",    32'(id_ok[1]), 32'd1);
    check("b_ts_ok",    32'(ts_ok[1]), 32'd1);
    check("b_ts_val",   tsv[1], 32'd0);
    check("b_id_val",   idv[1], EXP_ID);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sysid_check_master.md
# sysid_check_master

Avalon-MM read master that interrogates the system-ID slave at boot (or on demand) and reports whether the hardware matches what software was built for. It issues two single-word reads, ID at word address 0 and timestamp at word address 1, compares each against parameters, and exposes pass/fail status and captured values. It sits next to the Qsys interconnect as a standalone master, gating software start-up and driving a status LED.

## Interface
- EXPECTED_ID, 32'h0000_0000: value required at word address 0
- EXPECTED_TIMESTAMP, 32'h0000_0000: value required at word address 1
- CHECK_TIMESTAMP, 1: 0 skips the timestamp read; ts_ok then reports 1
- TIMEOUT_CYCLES, 1024: cycles allowed per read before aborting (1..65535)
- AUTO_START, 1: 1 launches a check on the first cycle after reset deasserts
- clock  in  1  system clock; everything is sampled on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; starts a check when idle, ignored otherwise
- avm_address  out  1  word address (0 = ID, 1 = timestamp)
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall; request held while high
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  readdata qualifier
- busy  out  1  check in progress
- done  out  1  check finished (level, held until next start)
- id_ok  out  1  captured ID equals EXPECTED_ID
- ts_ok  out  1  captured timestamp equals EXPECTED_TIMESTAMP
- timeout  out  1  a read exceeded TIMEOUT_CYCLES
- id_value  out  32  last captured ID
- ts_value  out  32  last captured timestamp

## Operation
- States: IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, FINISH.
- IDLE: a start pulse (or the post-reset cycle when AUTO_START=1) moves to REQ_ID. Entering REQ_ID clears done, id_ok, ts_ok, timeout, and resets the timeout counter.
- REQ_ID: avm_read=1, avm_address=0. While avm_waitrequest=1, stay and hold both outputs stable. When avm_waitrequest=0, the request is accepted: drop avm_read next cycle and go to WAIT_ID.
  - If avm_readdatavalid is asserted in the acceptance cycle itself (zero-latency slave), capture immediately and skip WAIT_ID.
- WAIT_ID: on avm_readdatavalid, capture avm_readdata into id_value and set id_ok = (data == EXPECTED_ID). Then go to REQ_TS, or to FINISH if CHECK_TIMESTAMP=0 (ts_ok=1, ts_value=0).
- REQ_TS / WAIT_TS: same rules with address 1. Capture into ts_value; ts_ok = compare.
- FINISH: set done=1, busy=0, then return to IDLE next cycle. done and the result flags hold until the next start.
- Timeout:
  - A 16-bit counter resets on entering each REQ state and increments every cycle spent in REQ_x or WAIT_x.
  - When the counter reaches TIMEOUT_CYCLES, set timeout=1, deassert avm_read, and go to FINISH. The flag of the unfinished read stays 0.
  - A readdatavalid arriving later in IDLE is ignored.
- Only one read is ever outstanding. readdatavalid seen in REQ_x before acceptance is ignored.
- Reset mid-transaction: everything returns to reset values next cycle. avm_read drops even if waitrequest is high; the interconnect tolerates the abandoned read only under reset.

## Timing
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0.
- All outputs are registered.
- avm_read rises the cycle after the start pulse, or the first cycle after reset drops with AUTO_START=1.
- busy is high from the cycle avm_read first rises through the cycle before done rises.
- Best case, zero-wait slave with readdatavalid in the acceptance cycle, both reads enabled: read at cycles 1 and 2, done=1 at cycle 3 after start.
- With one cycle of read latency per read: done=1 at cycle 5.
- Flags update in the same cycle as the corresponding value register: the edge after readdatavalid is sampled.
- A start that coincides with FINISH, or arrives while busy, is dropped.

## Test plan
- Nominal: EXPECTED_ID=32'h64A4_C5FC, EXPECTED_TIMESTAMP=32'h4C8F_1A20; slave returns both with 1-cycle latency, 0 waits -> done=1 at cycle 5, id_ok=1, ts_ok=1, timeout=0, exactly two reads on the bus.
- ID mismatch: slave returns 32'h0000_0001 at address 0 -> id_value=1, id_ok=0, timestamp still read, ts_ok=1, done=1.
- Waitrequest stall: waitrequest high for 7 cycles on the ID read -> avm_read and avm_address held stable all 7 cycles, single acceptance, result correct.
- Timeout: TIMEOUT_CYCLES=16, slave never asserts readdatavalid for address 1 -> timeout=1 and done=1 sixteen cycles after entering REQ_TS, ts_ok=0, avm_read=0. A late readdatavalid changes nothing.
- CHECK_TIMESTAMP=0 with a zero-latency slave -> one read only, done at cycle 2, ts_ok=1.
- Reset at cycle 2 of the ID read -> all outputs at reset values next cycle. With AUTO_START=1, a fresh check runs to completion.
